key_uart_tx: RTL and testbench

Downstream consumer of the PS/2 keyboard decoder. Takes one-cycle key events (ASCII code) from the decoder, buffers them in a small FIFO, and serialises each non-zero ASCII byte onto a UART line as 8N1, LSB first. This lets typed characters be forwarded to the host over the design's UART link, with a sticky overflow flag for events lost while the FIFO is full.

---
 rtl/key_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_key_uart_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_uart_tx.sv
// Key-event UART transmitter: queues non-zero ASCII key events in a small FIFO
// and sends each one as an 8N1 frame (LSB first) with back-to-back frames when queued.
module key_uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          key_valid,
  input  logic [7:0]                    key_ascii,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [1:0]                    o_dbg_state
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_baud_cnt;
  logic [CW-1:0]   w_baud_next;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_next;
  logic [2:0]      w_next_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            w_tx_next;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_overflow;

  logic            w_baud_done;
  logic            w_have_data;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;

  assign w_baud_done = (r_baud_cnt == BAUD_LAST);
  assign w_have_data = (r_count != '0);
  assign w_next_bit  = r_bit_idx + 3'd1;

  // key_valid has no back-pressure: a non-zero byte is taken when there is room,
  // where a pop on the same edge counts as room; otherwise it is lost and flagged.
  assign w_push_req = key_valid && (key_ascii != 8'd0);
  assign w_push     = w_push_req && ((r_count < DEPTH_C) || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_have_data) begin
          w_next_state = S_START;
          w_pop        = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_done) w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_baud_done && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (w_have_data) begin
            w_next_state = S_START;
            w_pop        = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_next      = 1'b1;
    w_baud_next    = '0;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      S_IDLE: begin
        w_tx_next      = !w_pop;
        w_bit_idx_next = 3'd0;
      end
      S_START: begin
        w_tx_next      = w_baud_done ? r_shift[0] : 1'b0;
        w_baud_next    = w_baud_done ? '0 : r_baud_cnt + CW'(1);
        w_bit_idx_next = 3'd0;
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_tx_next      = (r_bit_idx == 3'd7) ? 1'b1 : r_shift[w_next_bit];
          w_bit_idx_next = w_next_bit;
        end else begin
          w_tx_next   = r_shift[r_bit_idx];
          w_baud_next = r_baud_cnt + CW'(1);
        end
      end
      S_STOP: begin
        w_tx_next   = !w_pop;
        w_baud_next = w_baud_done ? '0 : r_baud_cnt + CW'(1);
      end
      default: begin
        w_tx_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
    end else begin
      r_baud_cnt <= w_baud_next;
      r_bit_idx  <= w_bit_idx_next;
      r_tx       <= w_tx_next;
      if (w_pop) r_shift <= r_mem[r_rd_ptr];
    end
  end

  // Storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= key_ascii;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  assign uart_tx     = r_tx;
  assign busy        = (r_state != S_IDLE);
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_uart_tx.sv
// Bench for key_uart_tx: frame-level reference model, per-cycle output compare,
// UART line decoder feeding a byte scoreboard, directed cases and random traffic.
module tb_key_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
  localparam int FRAME   = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_ascii = 8'd0;
  logic       uart_tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  key_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .key_valid  (key_valid),
    .key_ascii  (key_ascii),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting bytes plus a frame timer 0..FRAME-1.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_active;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_ovf;

  function automatic void model_clear();
    m_q.delete();
    exp_q.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_byte   = 8'd0;
    m_ovf    = 1'b0;
  endfunction

  function automatic void model_step();
    bit do_pop, req, acc;
    do_pop = (m_q.size() > 0) && (!m_active || m_t == FRAME - 1);
    req    = key_valid && (key_ascii != 8'd0);
    acc    = req && ((m_q.size() < DEPTH) || do_pop);
    if (do_pop) begin
      m_byte   = m_q.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end else if (m_active) begin
      if (m_t == FRAME - 1) m_active = 1'b0;
      else m_t++;
    end
    if (acc) begin
      m_q.push_back(key_ascii);
      exp_q.push_back(key_ascii);
    end else if (req) begin
      m_ovf = 1'b1;
    end
  endfunction

  function automatic logic exp_line();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (!resetn) model_clear();
      else model_step();
    end
  end

  // Per-cycle compare plus a line decoder that scores every received byte.
  int         mon_timer = 0;
  int         mon_pos = 0;
  int         frames_seen = 0;
  logic [7:0] mon_byte = 8'd0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("uart_tx", uart_tx, exp_line());
      check("busy", busy, m_active);
      check("fifo_count", fifo_count, m_q.size());
      check("overflow", overflow, m_ovf);
      if (!resetn) begin
        mon_timer = 0;
      end else if (mon_timer == 0) begin
        if (uart_tx == 1'b0) begin
          frames_seen++;
          mon_timer = FRAME - 1;
          mon_pos   = 0;
        end
      end else begin
        mon_pos++;
        mon_timer--;
        if ((mon_pos % CLK_DIV == CLK_DIV / 2) && (mon_pos / CLK_DIV >= 1) && (mon_pos / CLK_DIV <= 8))
          mon_byte[mon_pos/CLK_DIV-1] = uart_tx;
        if (mon_pos == FRAME - CLK_DIV / 2) begin
          logic [31:0] e;
          e = 32'hxxxx_xxxx;
          if (exp_q.size() > 0) e = {24'd0, exp_q.pop_front()};
          check("stop_bit", uart_tx, 1);
          check("frame_byte", {24'd0, mon_byte}, e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] a);
    key_valid = v;
    key_ascii = a;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0);
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'd0;
    model_clear();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", (n < budget), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] line;
    logic       tx_s [0:131];
    logic       busy_s [0:131];
    logic [7:0] dec;
    int         busy_cnt, peak, f0;

    repeat (2) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    resetn = 1'b1;
    idle(2);

    // Single 'A' frame: latency, bit pattern, busy width.
    drive(1'b1, 8'h41);
    check("t1_count_after_e0", fifo_count, 1);
    check("t1_tx_after_e0", uart_tx, 1);
    drive(1'b0, 8'd0);
    check("t1_tx_falls", uart_tx, 0);
    check("t1_busy_rises", busy, 1);
    check("t1_count_back", fifo_count, 0);
    line = '0;
    busy_cnt = 0;
    for (int t = 0; t < 50; t++) begin
      if (t < 40 && (t % 4) == 2) line[t/4] = uart_tx;
      if (busy) busy_cnt++;
      drive(1'b0, 8'd0);
    end
    check("t1_line_bits", line, 10'b10_1000_0010);
    check("t1_busy_cycles", busy_cnt, 40);
    check("t1_count_end", fifo_count, 0);

    // Zero code is ignored.
    drive(1'b1, 8'h00);
    check("t2_count", fifo_count, 0);
    idle(5);
    check("t2_tx", uart_tx, 1);
    check("t2_busy", busy, 0);
    check("t2_overflow", overflow, 0);

    // Three consecutive events sent back to back.
    peak = 0;
    for (int c = 0; c < 132; c++) begin
      drive(c < 3, (c < 3) ? 8'(8'h31 + c) : 8'd0);
      if (fifo_count > peak) peak = fifo_count;
      tx_s[c]   = uart_tx;
      busy_s[c] = busy;
    end
    busy_cnt = 0;
    for (int c = 0; c < 132; c++) if (busy_s[c]) busy_cnt++;
    check("t3_peak_count", peak, 2);
    check("t3_busy_cycles", busy_cnt, 120);
    check("t3_busy_last", busy_s[120], 1);
    check("t3_idle_after", busy_s[121], 0);
    check("t3_start0", {tx_s[0], tx_s[1]}, 2'b10);
    check("t3_start1", {tx_s[40], tx_s[41]}, 2'b10);
    check("t3_start2", {tx_s[80], tx_s[81]}, 2'b10);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) dec[j] = tx_s[1 + 40*k + 4*(j+1) + 2];
      check("t3_byte", dec, 8'h31 + k);
    end

    // Overflow: nine pushes during the first frame, ninth dropped.
    do_reset();
    f0 = frames_seen;
    drive(1'b1, 8'h60);
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 8'(8'h60 + i));
      if (i == 8) begin
        check("t4_full_count", fifo_count, 8);
        check("t4_no_ovf_yet", overflow, 0);
      end
    end
    check("t4_sat_count", fifo_count, 8);
    check("t4_overflow", overflow, 1);
    idle(1);
    wait_idle(1000);
    check("t4_frames", frames_seen - f0, 9);

    // Write on the pop edge while full is accepted.
    do_reset();
    drive(1'b1, 8'h70);
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(8'h70 + i));
    check("t5_full_count", fifo_count, 8);
    idle(32);
    drive(1'b1, 8'h7f);
    check("t5_count_on_pop", fifo_count, 8);
    check("t5_no_overflow", overflow, 0);
    check("t5_next_start", uart_tx, 0);
    idle(1);
    wait_idle(1000);

    // Reset during data bit 3.
    do_reset();
    drive(1'b1, 8'h55);
    idle(18);
    check("t6_bit3_before", uart_tx, 0);
    check("t6_busy_before", busy, 1);
    resetn = 1'b0;
    model_clear();
    #1;
    check("t6_rst_tx", uart_tx, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", fifo_count, 0);
    idle(3);
    resetn = 1'b1;
    f0 = frames_seen;
    idle(60);
    check("t6_no_frame", frames_seen - f0, 0);
    check("t6_tx_idle", uart_tx, 1);

    // Random traffic with varying density and one reset.
    for (int seg = 0; seg < 6; seg++) begin
      int density, len;
      density = $urandom_range(5, 90);
      len     = $urandom_range(150, 300);
      if (seg == 3) do_reset();
      for (int c = 0; c < len; c++) begin
        logic       v;
        logic [7:0] a;
        v = ($urandom_range(0, 99) < density);
        a = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        drive(v, a);
      end
    end
    idle(1);
    wait_idle(2000);
    idle(2);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
